// File: rtl/instr_loader_if.sv
// ----------------------------------------------------------------------------
// instr_loader_if
//   Bundles the two buses of the program loader:
//   - Byte stream from the host link (valid/ready).
//   - Sequential write port into the instruction memory.
//
// Handshake rule for the byte stream:
//   - A byte moves on a rising clock edge where in_valid and in_ready are
//     both high.
//   - The host keeps in_data stable while in_valid is high and in_ready is low.
//   - in_ready never depends on in_valid.
//
// Signals:
//   in_valid  host -> loader  byte available on in_data
//   in_data   host -> loader  stream byte
//   in_ready  loader -> host  loader accepts in_data this cycle
//   we        loader -> imem  write enable, one cycle per word
//   waddr     loader -> imem  word address
//   wdata     loader -> imem  32-bit instruction word
//
// Modports:
//   master    host / memory side (testbench or bridge)
//   slave     the loader itself
// ----------------------------------------------------------------------------
interface instr_loader_if #(
   parameter int ADDR_W = 10
);
   logic              in_valid;
   logic [7:0]        in_data;
   logic              in_ready;
   logic              we;
   logic [ADDR_W-1:0] waddr;
   logic [31:0]       wdata;

   modport master (
      output in_valid,
      output in_data,
      input  in_ready,
      input  we,
      input  waddr,
      input  wdata
   );

   modport slave (
      input  in_valid,
      input  in_data,
      output in_ready,
      output we,
      output waddr,
      output wdata
   );
endinterface

// File: rtl/instr_loader.sv
// ----------------------------------------------------------------------------
// instr_loader
//   Writer-side companion to the instruction memory.
//   - Takes a framed byte stream from a host link.
//   - Assembles little-endian 32-bit words and writes them to consecutive
//     word addresses starting at BASE_ADDR.
//   - Keeps the core stalled (busy) while the image loads.
//   - Checks an XOR checksum and reports done/err.
//
// Frame layout:
//   CNT_LO, CNT_HI, 4*N data bytes (LSB first per word), CHK
//   CHK = XOR of every preceding frame byte, including the header.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   start        one-cycle pulse, starts a load when idle
//   bus          instr_loader_if.slave: byte stream in, memory write port out
//   busy         load in progress (stall the core)
//   done         sticky, last load finished with a good checksum
//   err          sticky, last load failed (bad count or bad checksum)
//   dbg_state_o  current FSM state, for debug and assertion binding
// ----------------------------------------------------------------------------
module instr_loader #(
   parameter int ADDR_W    = 10,
   parameter int BASE_ADDR = 0,
   parameter int MAX_WORDS = 1024
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   instr_loader_if.slave bus,
   output logic         busy,
   output logic         done,
   output logic         err,
   output logic [2:0]   dbg_state_o
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_HDR0  = 3'd1,
      S_HDR1  = 3'd2,
      S_DATA  = 3'd3,
      S_WRITE = 3'd4,
      S_CHK   = 3'd5,
      S_DONE  = 3'd6,
      S_ERR   = 3'd7
   } state_t;

   // Range-check constants, widened so BASE_ADDR + N cannot overflow.
   localparam logic [32:0] ADDR_SPACE = 33'(1) << ADDR_W;
   localparam logic [32:0] BASE_EXT   = 33'(BASE_ADDR);
   localparam logic [32:0] MAX_EXT    = 33'(MAX_WORDS);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] waddr_q, waddr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [15:0]       remain_q, remain_d;
   logic [1:0]        byte_idx_q, byte_idx_d;
   logic [7:0]        chk_q, chk_d;
   logic [7:0]        cnt_lo_q, cnt_lo_d;
   logic              done_q, done_d;
   logic              err_q, err_d;

   logic              in_ready_c;
   logic              we_c;
   logic              busy_c;
   logic              accept;
   logic [15:0]       hdr_count;
   logic [32:0]       hdr_count_ext;
   logic              count_bad;
   logic              chk_match;

   assign accept        = bus.in_valid & in_ready_c;

   // Word count as it stands once CNT_HI is on the bus.
   assign hdr_count     = {bus.in_data, cnt_lo_q};
   assign hdr_count_ext = {17'b0, hdr_count};
   assign count_bad     = (hdr_count_ext > MAX_EXT) ||
                          ((BASE_EXT + hdr_count_ext) > ADDR_SPACE);
   assign chk_match     = (bus.in_data == chk_q);

   // -------------------------------------------------------------------------
   // FSM: state register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // -------------------------------------------------------------------------
   // FSM: next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (start) state_d = S_HDR0;
         end
         S_HDR0: begin
            if (accept) state_d = S_HDR1;
         end
         S_HDR1: begin
            if (accept) begin
               if (count_bad)            state_d = S_ERR;
               else if (hdr_count == '0) state_d = S_CHK;
               else                      state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (accept && (byte_idx_q == 2'd3)) state_d = S_WRITE;
         end
         S_WRITE: begin
            state_d = (remain_q == 16'd1) ? S_CHK : S_DATA;
         end
         S_CHK: begin
            if (accept) state_d = chk_match ? S_DONE : S_ERR;
         end
         S_DONE:  state_d = S_IDLE;
         S_ERR:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // -------------------------------------------------------------------------
   // FSM: output logic (purely a function of the current state)
   // -------------------------------------------------------------------------
   always_comb begin
      in_ready_c = 1'b0;
      we_c       = 1'b0;
      busy_c     = 1'b0;
      case (state_q)
         S_HDR0, S_HDR1, S_DATA, S_CHK: begin
            in_ready_c = 1'b1;
            busy_c     = 1'b1;
         end
         S_WRITE: begin
            we_c   = 1'b1;
            busy_c = 1'b1;
         end
         default: begin
            in_ready_c = 1'b0;
            we_c       = 1'b0;
            busy_c     = 1'b0;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Datapath next-state: counters, address, word assembly, checksum, flags
   // -------------------------------------------------------------------------
   always_comb begin
      waddr_d    = waddr_q;
      wdata_d    = wdata_q;
      remain_d   = remain_q;
      byte_idx_d = byte_idx_q;
      chk_d      = chk_q;
      cnt_lo_d   = cnt_lo_q;
      done_d     = done_q;
      err_d      = err_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               done_d     = 1'b0;
               err_d      = 1'b0;
               chk_d      = 8'h00;
               byte_idx_d = 2'd0;
               waddr_d    = ADDR_W'(BASE_ADDR);
            end
         end
         S_HDR0: begin
            if (accept) begin
               chk_d    = chk_q ^ bus.in_data;
               cnt_lo_d = bus.in_data;
            end
         end
         S_HDR1: begin
            if (accept) begin
               chk_d    = chk_q ^ bus.in_data;
               remain_d = hdr_count;
               if (count_bad) err_d = 1'b1;
            end
         end
         S_DATA: begin
            if (accept) begin
               chk_d                       = chk_q ^ bus.in_data;
               wdata_d[8*byte_idx_q +: 8]  = bus.in_data;
               // Wraps 3 -> 0, ready for the next word.
               byte_idx_d                  = byte_idx_q + 2'd1;
            end
         end
         S_WRITE: begin
            remain_d = remain_q - 16'd1;
            // The address is not advanced past the last word, so a load that
            // ends at the top of memory leaves waddr at 2**ADDR_W-1.
            if (remain_q != 16'd1) waddr_d = waddr_q + 1'b1;
         end
         S_CHK: begin
            if (accept) begin
               if (chk_match) done_d = 1'b1;
               else           err_d  = 1'b1;
            end
         end
         default: begin
            waddr_d = waddr_q;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         waddr_q    <= '0;
         wdata_q    <= '0;
         remain_q   <= '0;
         byte_idx_q <= '0;
         chk_q      <= '0;
         cnt_lo_q   <= '0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         waddr_q    <= waddr_d;
         wdata_q    <= wdata_d;
         remain_q   <= remain_d;
         byte_idx_q <= byte_idx_d;
         chk_q      <= chk_d;
         cnt_lo_q   <= cnt_lo_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   assign bus.in_ready = in_ready_c;
   assign bus.we       = we_c;
   assign bus.waddr    = waddr_q;
   assign bus.wdata    = wdata_q;
   assign busy         = busy_c;
   assign done         = done_q;
   assign err          = err_q;
   assign dbg_state_o  = state_q;

endmodule
